// File: rtl/pll_lock_sequencer_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL lock sequencer.
//   seq_state_e : sequencer states
//   RETRY_W     : width of the retry counter
//   LOSS_W      : width of the optional lock-loss event counter
//   cnt_width() : width of the shared cycle counter for a set of limits
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } seq_state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // One counter serves every timed state, so it is sized for the largest
  // limit, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_bit.sv
// sync_bit: N-stage single-bit synchroniser into the clk domain.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, output resets to 0
//   d     : asynchronous input bit
//   q     : synchronised output (N clk edges of latency)
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences PLL power-up, lock qualification and
// lock-loss recovery, and produces a REF_CLK_0-domain system reset that is
// released only once lock has been stable for STABLE_CYCLES.
//   REF_CLK_0         : free-running reference clock (only clock)
//   RESET_N           : asynchronous active-low reset
//   PLL_LOCK_0        : PLL lock, asynchronous, synchronised internally
//   RESTART           : one-cycle pulse, restart from PWRDN, clear FAIL/retries
//   PLL_POWERDOWN_N_0 : to the PLL, 0 = power down
//   SYS_RESET_N       : system reset, active low, high only in RUN
//   READY             : high in RUN
//   FAIL              : sticky, set when retries are exhausted
//   LOCK_LOST         : one-cycle pulse when lock drops in RUN
//   RETRY_COUNT       : power-cycle attempts consumed
//   dbg_state         : current sequencer state, for debug/checkers
//   LOSS_COUNT        : saturating count of LOCK_LOST events, present only
//                       when PLL_LOCK_SEQ_LOSS_CNT_EN is defined; cleared by
//                       RESET_N only
// All outputs are registered.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2
) (
  input  logic               REF_CLK_0,
  input  logic               RESET_N,
  input  logic               PLL_LOCK_0,
  input  logic               RESTART,
  output logic               PLL_POWERDOWN_N_0,
  output logic               SYS_RESET_N,
  output logic               READY,
  output logic               FAIL,
  output logic               LOCK_LOST,
  output logic [RETRY_W-1:0] RETRY_COUNT,
  output logic [2:0]         dbg_state
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  ,
  output logic [LOSS_W-1:0]  LOSS_COUNT
`endif
);

  localparam int CNT_W = cnt_width(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   PD_LAST = CNT_W'(PD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   ST_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic lock_s;

  sync_bit #(.N(SYNC_STAGES)) u_lock_sync (
    .clk   (REF_CLK_0),
    .rst_n (RESET_N),
    .d     (PLL_LOCK_0),
    .q     (lock_s)
  );

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pd_n_q, pd_n_d;
  logic               sys_rst_n_q, sys_rst_n_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;
  logic               lock_lost_q, lock_lost_d;

  // cnt_q holds the number of cycles already spent in the current state and
  // is cleared on every state entry, so a state with limit L expires on the
  // edge where cnt_q == L-1.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;

    if (RESTART) begin
      state_d = PWRDN;
      retry_d = '0;
    end else begin
      case (state_q)
        PWRDN: begin
          if (cnt_q == PD_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = PWRDN;
            end else begin
              state_d = FAILED;
            end
          end
        end
        STABLE: begin
          // A drop on the expiry cycle itself still wins over RUN.
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == ST_LAST) state_d = RUN;
        end
        RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            state_d     = STABLE;
            lock_lost_d = 1'b1;
          end
        end
        FAILED: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = PWRDN;
        end
      endcase
    end

    // RESTART re-enters PWRDN even from PWRDN, so it also clears the count.
    if (RESTART || (state_d != state_q)) cnt_d = '0;

    // Outputs are registered from the next state so they line up with it.
    pd_n_d      = (state_d == WAIT_LOCK) || (state_d == STABLE) || (state_d == RUN);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fail_d      = (state_d == FAILED);
  end

  always_ff @(posedge REF_CLK_0 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= PWRDN;
      cnt_q       <= '0;
      retry_q     <= '0;
      pd_n_q      <= 1'b0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pd_n_q      <= pd_n_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign PLL_POWERDOWN_N_0 = pd_n_q;
  assign SYS_RESET_N       = sys_rst_n_q;
  assign READY             = ready_q;
  assign FAIL              = fail_q;
  assign LOCK_LOST         = lock_lost_q;
  assign RETRY_COUNT       = retry_q;
  assign dbg_state         = state_q;

`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q, loss_d;

  always_comb begin
    loss_d = loss_q;
    if (lock_lost_d && (loss_q != '1)) loss_d = loss_q + 1'b1;
  end

  always_ff @(posedge REF_CLK_0 or negedge RESET_N) begin
    if (!RESET_N) begin
      loss_q <= '0;
    end else begin
      loss_q <= loss_d;
    end
  end

  assign LOSS_COUNT = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed bring-up/glitch/timeout/restart/reset
// scenarios with literal cycle-count expectations, followed by randomized
// lock toggling and restarts, all checked every cycle against a behavioural
// model of the sequencing rules.
module tb_pll_lock_sequencer;

  localparam int P_PD     = 4;
  localparam int P_TO     = 32;
  localparam int P_STABLE = 8;
  localparam int P_RETRY  = 2;
  localparam int P_SYNC   = 2;

  logic       clk;
  logic       rst_n;
  logic       pll_lock;
  logic       restart;
  logic       pd_n;
  logic       sys_rst_n;
  logic       ready;
  logic       fail;
  logic       lock_lost;
  logic [3:0] retry_count;
  logic [2:0] dbg_state;
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_count;
`endif

  int total = 0;
  int bad   = 0;

  pll_lock_sequencer #(
    .PD_CYCLES     (P_PD),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STABLE),
    .MAX_RETRIES   (P_RETRY),
    .SYNC_STAGES   (P_SYNC)
  ) dut (
    .REF_CLK_0         (clk),
    .RESET_N           (rst_n),
    .PLL_LOCK_0        (pll_lock),
    .RESTART           (restart),
    .PLL_POWERDOWN_N_0 (pd_n),
    .SYS_RESET_N       (sys_rst_n),
    .READY             (ready),
    .FAIL              (fail),
    .LOCK_LOST         (lock_lost),
    .RETRY_COUNT       (retry_count),
    .dbg_state         (dbg_state)
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    ,
    .LOSS_COUNT        (loss_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Modes of the sequence; m_t is how many cycles have elapsed in the mode.
  localparam int M_PD = 0, M_WAIT = 1, M_STAB = 2, M_RUN = 3, M_FAIL = 4;
  int   m_mode;
  int   m_t;
  int   m_retry;
  bit   m_fail;
  bit   m_lost;
  int   m_loss;
  logic hist[$];   // raw lock samples of the last P_SYNC edges, oldest first

  task automatic model_reset();
    m_mode  = M_PD;
    m_t     = 0;
    m_retry = 0;
    m_fail  = 0;
    m_lost  = 0;
    m_loss  = 0;
    hist.delete();
    for (int i = 0; i < P_SYNC; i++) hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic raw, input logic rs);
    logic ls;
    int   nm;
    int   done;
    ls     = hist[0];
    nm     = m_mode;
    done   = m_t + 1;   // cycles completed in this mode including this one
    m_lost = 0;
    if (rs) begin
      nm      = M_PD;
      m_retry = 0;
      m_fail  = 0;
    end else begin
      if (m_mode == M_PD) begin
        if (done >= P_PD) nm = M_WAIT;
      end else if (m_mode == M_WAIT) begin
        if (ls) nm = M_STAB;
        else if (done >= P_TO) begin
          if (m_retry < P_RETRY) begin
            m_retry++;
            nm = M_PD;
          end else begin
            m_fail = 1;
            nm     = M_FAIL;
          end
        end
      end else if (m_mode == M_STAB) begin
        if (!ls) nm = M_WAIT;
        else if (done >= P_STABLE) nm = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (!ls) begin
          nm     = M_STAB;
          m_lost = 1;
          if (m_loss < 255) m_loss++;
        end
      end
    end
    m_t    = (rs || nm != m_mode) ? 0 : m_t + 1;
    m_mode = nm;
    hist.push_back(raw);
    void'(hist.pop_front());
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(pll_lock, restart);
  end

  // Compare process: every cycle out of reset, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_pd_n",   pd_n,        (m_mode == M_WAIT || m_mode == M_STAB || m_mode == M_RUN));
      chk("m_srst_n", sys_rst_n,   (m_mode == M_RUN));
      chk("m_ready",  ready,       (m_mode == M_RUN));
      chk("m_fail",   fail,        m_fail);
      chk("m_lost",   lock_lost,   m_lost);
      chk("m_retry",  retry_count, m_retry);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
      chk("m_loss",   loss_count,  m_loss);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return pd_n;
      1:       return sys_rst_n;
      default: return fail;
    endcase
  endfunction

  // Counts edges until the selected output reaches val; the count is checked.
  task automatic wait_for(input string name, input int sel, input logic val,
                          input int budget, input int exp_n);
    int n;
    n = 0;
    while (sig(sel) !== val && n < budget) begin
      step();
      n++;
    end
    chk(name, n, exp_n);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int lowrun;
    int pulses;
    int good_w;
    int hold;

    rst_n    = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    #12;
    chk("rst_pd_n",  pd_n, 0);
    chk("rst_srst",  sys_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fail",  fail, 0);
    chk("rst_lost",  lock_lost, 0);
    chk("rst_retry", retry_count, 0);
    #10 rst_n = 1'b1;

    // Normal bring-up: lock raised 20 cycles after reset release.
    wait_for("bringup_pd_rise", 0, 1'b1, 50, 4);
    repeat (16) step();
    pll_lock = 1'b1;
    wait_for("bringup_srst_lat", 1, 1'b1, 50, 11);
    chk("bringup_ready", ready, 1);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    wait_for("loss_srst_fall", 1, 1'b0, 20, 3);
    chk("loss_pulse_hi", lock_lost, 1);
    chk("loss_ready", ready, 0);
    step();
    chk("loss_pulse_lo", lock_lost, 0);
`ifdef PLL_LOCK_SEQ_LOSS_CNT_EN
    chk("loss_count", loss_count, 1);
`endif

    // Glitch in STABLE landing on the expiry cycle: no release.
    pll_lock = 1'b1;
    repeat (8) step();
    pll_lock = 1'b0;
    repeat (3) step();
    chk("glitch_no_release", sys_rst_n, 0);
    pll_lock = 1'b1;
    wait_for("glitch_srst_lat", 1, 1'b1, 50, 11);
    chk("glitch_retry", retry_count, 0);

    // RESTART mid-STABLE.
    pll_lock = 1'b0;
    step();
    pll_lock = 1'b1;
    repeat (6) step();
    pulse_restart();
    chk("rs_stab_fail", fail, 0);
    chk("rs_stab_retry", retry_count, 0);
    chk("rs_stab_pd", pd_n, 0);
    chk("rs_stab_srst", sys_rst_n, 0);
    wait_for("rs_stab_pd_len", 0, 1'b1, 50, 4);
    wait_for("rs_stab_relock", 1, 1'b1, 50, 9);

    // Timeouts and retries with lock held low.
    pll_lock = 1'b0;
    pulse_restart();
    n = 0; lowrun = 1; pulses = 0; good_w = 0;
    while (fail !== 1'b1 && n < 400) begin
      step();
      n++;
      if (pd_n === 1'b0) lowrun++;
      else begin
        if (lowrun > 0) begin
          pulses++;
          if (lowrun == P_PD) good_w++;
        end
        lowrun = 0;
      end
    end
    chk("to_cycles", n, 108);
    chk("to_pulses", pulses, 3);
    chk("to_pulse_w", good_w, 3);
    chk("to_retry", retry_count, 2);
    chk("to_pd", pd_n, 0);
    chk("to_srst", sys_rst_n, 0);
    repeat (5) step();
    chk("to_fail_sticky", fail, 1);

    // RESTART from FAILED, then lock.
    pulse_restart();
    chk("rs_fail_fail", fail, 0);
    chk("rs_fail_retry", retry_count, 0);
    wait_for("rs_fail_pd_len", 0, 1'b1, 50, 4);
    pll_lock = 1'b1;
    wait_for("rs_fail_relock", 1, 1'b1, 50, 11);

    // Asynchronous reset mid-RUN, away from a clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pd_n",  pd_n, 0);
    chk("arst_srst",  sys_rst_n, 0);
    chk("arst_ready", ready, 0);
    chk("arst_fail",  fail, 0);
    chk("arst_lost",  lock_lost, 0);
    chk("arst_retry", retry_count, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    wait_for("arst_pd_rise", 0, 1'b1, 50, 4);
    wait_for("arst_srst_rise", 1, 1'b1, 50, 9);

    // Randomized lock behaviour with occasional restarts.
    for (int seg = 0; seg < 400; seg++) begin
      pll_lock = ~pll_lock;
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) step();
      if ($urandom_range(0, 19) == 0) pulse_restart();
    end
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
